fib_checker: RTL and testbench

Receive-side checker for the 8-bit Fibonacci sequencer stream. It samples the sequencer output on a valid strobe and checks every term against the sum of the two preceding terms, modulo 2^WIDTH. It reports lock, mismatch pulses and saturating counters. It sits downstream of the sequencer as a self-check monitor in the tutorial design and can be synthesised alongside it.

---
 rtl/fib_checker.sv | 123 ++++++++++++
 tb/tb_fib_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_checker.sv
// Receive-side Fibonacci stream checker: seeds from two samples, then checks each term mod 2^WIDTH.
// Optional FIB_CHK_STRICT_SEED_EN restricts seeds to the canonical 1, 1 start.
module fib_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LOCK_THRESH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             fib_valid,
  input  logic [WIDTH-1:0] fib_in,
  output logic             locked,
  output logic             err,
  output logic [WIDTH-1:0] expected,
  output logic [7:0]       err_count,
  output logic [7:0]       term_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] RUN_MAX = CW'(LOCK_THRESH);

  typedef enum logic [1:0] {IDLE, SEED1, TRACK} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  prev_q, prev2_q, expected_q;
  logic [CW-1:0]     match_run_q, err_cnt_q, term_cnt_q;
  logic              locked_q, err_q;

  logic [CW-1:0]     err_cnt_d, term_cnt_d, match_run_d;
  logic              match_c;

  // Saturating increments of the counters and the match run
  assign err_cnt_d   = (err_cnt_q == '1) ? err_cnt_q : CW'(err_cnt_q + CW'(1));
  assign term_cnt_d  = (term_cnt_q == '1) ? term_cnt_q : CW'(term_cnt_q + CW'(1));
  assign match_run_d = (match_run_q >= RUN_MAX) ? match_run_q : CW'(match_run_q + CW'(1));
  assign match_c     = (fib_in == expected_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      prev2_q     <= '0;
      expected_q  <= '0;
      match_run_q <= '0;
      err_cnt_q   <= '0;
      term_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      prev2_q     <= '0;
      expected_q  <= '0;
      match_run_q <= '0;
      err_cnt_q   <= '0;
      term_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (fib_valid) begin
        unique case (state_q)
          IDLE: begin
`ifdef FIB_CHK_STRICT_SEED_EN
            if (fib_in != WIDTH'(1)) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_d;
            end else
`endif
            begin
              prev2_q <= fib_in;
              state_q <= SEED1;
            end
          end
          SEED1: begin
`ifdef FIB_CHK_STRICT_SEED_EN
            if (fib_in != WIDTH'(1)) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= IDLE;
            end else
`endif
            begin
              prev_q     <= fib_in;
              expected_q <= WIDTH'(prev2_q + fib_in);
              state_q    <= TRACK;
            end
          end
          TRACK: begin
            if (match_c) begin
              prev2_q     <= prev_q;
              prev_q      <= fib_in;
              expected_q  <= WIDTH'(prev_q + fib_in);
              term_cnt_q  <= term_cnt_d;
              match_run_q <= match_run_d;
              locked_q    <= (match_run_d == RUN_MAX);
            end else begin
              // Mismatch: report, drop lock and resynchronise on the offending sample
              err_q       <= 1'b1;
              err_cnt_q   <= err_cnt_d;
              locked_q    <= 1'b0;
              match_run_q <= '0;
`ifdef FIB_CHK_STRICT_SEED_EN
              state_q     <= IDLE;
`else
              prev2_q     <= fib_in;
              state_q     <= SEED1;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign expected   = expected_q;
  assign err_count  = err_cnt_q;
  assign term_count = term_cnt_q;

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker: directed vector table, gap/clear and saturation sequences,
// then random stimulus against a queue-based model of the sequence rules.
module tb_fib_checker;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned THRESH = 2;

  logic             clock, reset, clear, fib_valid;
  logic [WIDTH-1:0] fib_in;
  logic             locked, err;
  logic [WIDTH-1:0] expected;
  logic [7:0]       err_count, term_count;

  int ncmp = 0;
  int nerr = 0;

  fib_checker #(.WIDTH(WIDTH), .LOCK_THRESH(THRESH)) dut (
    .clock(clock), .reset(reset), .clear(clear), .fib_valid(fib_valid), .fib_in(fib_in),
    .locked(locked), .err(err), .expected(expected),
    .err_count(err_count), .term_count(term_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic       c;
    logic [7:0] d;
    logic       e_err;
    logic       e_lk;
    logic [7:0] e_exp;
    logic [7:0] e_tc;
    logic [7:0] e_ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic c, input int d, input logic e_err,
                              input logic e_lk, input int e_exp, input int e_tc, input int e_ec);
    vec_t r;
    r.v = v; r.c = c; r.d = 8'(d); r.e_err = e_err; r.e_lk = e_lk;
    r.e_exp = 8'(e_exp); r.e_tc = 8'(e_tc); r.e_ec = 8'(e_ec);
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_err, input logic e_lk,
                           input int e_exp, input int e_tc, input int e_ec);
    chk({tag, ".err"},        32'(err),        32'(e_err));
    chk({tag, ".locked"},     32'(locked),     32'(e_lk));
    chk({tag, ".expected"},   32'(expected),   32'(e_exp));
    chk({tag, ".term_count"}, 32'(term_count), 32'(e_tc));
    chk({tag, ".err_count"},  32'(err_count),  32'(e_ec));
  endtask

  task automatic apply(input logic v, input logic c, input logic [7:0] d);
    fib_valid = v;
    clear     = c;
    fib_in    = d;
    @(posedge clock);
    #1;
    fib_valid = 1'b0;
    clear     = 1'b0;
  endtask

  // Reference model: the last accepted terms since synchronisation, kept as a short history
  int   hist[$];
  int   m_run, m_tc, m_ec, m_exp;
  logic m_err, m_lk;

  function automatic void model_reset();
    hist.delete();
    m_run = 0; m_tc = 0; m_ec = 0; m_exp = 0; m_err = 1'b0; m_lk = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic c, input int d);
    int want;
    m_err = 1'b0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    if (hist.size() < 2) begin
`ifdef FIB_CHK_STRICT_SEED_EN
      if (d != 1) begin
        m_err = 1'b1;
        m_ec  = (m_ec < 255) ? m_ec + 1 : 255;
        hist.delete();
        return;
      end
`endif
      hist.push_back(d);
      if (hist.size() == 2) m_exp = (hist[0] + hist[1]) % 256;
    end else begin
      want = (hist[hist.size()-1] + hist[hist.size()-2]) % 256;
      if (d == want) begin
        m_tc  = (m_tc < 255) ? m_tc + 1 : 255;
        m_run = (m_run < THRESH) ? m_run + 1 : THRESH;
        m_lk  = (m_run == THRESH);
        hist.push_back(d);
        hist.pop_front();
        m_exp = (hist[0] + hist[1]) % 256;
      end else begin
        m_err = 1'b1;
        m_ec  = (m_ec < 255) ? m_ec + 1 : 255;
        m_run = 0;
        m_lk  = 1'b0;
        hist.delete();
`ifndef FIB_CHK_STRICT_SEED_EN
        hist.push_back(d);
`endif
      end
    end
  endfunction

  int gap_d[3]   = '{1, 1, 2};
  int gap_exp[3] = '{0, 2, 3};
  int gap_tc[3]  = '{0, 0, 1};

  initial begin
    logic       v, c;
    logic [7:0] d;

    reset = 1'b1; clear = 1'b0; fib_valid = 1'b0; fib_in = '0;
    #12;
    check_all("reset", 1'b0, 1'b0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

`ifdef FIB_CHK_STRICT_SEED_EN
    add(1,0,2,  1,0,0,0,1);
    add(0,0,0,  0,0,0,0,1);
    add(1,0,1,  0,0,0,0,1);
    add(1,0,5,  1,0,0,0,2);
    add(1,0,1,  0,0,0,0,2);
    add(1,0,1,  0,0,2,0,2);
    add(1,0,2,  0,0,3,1,2);
    add(1,0,4,  1,0,3,1,3);
    add(1,0,1,  0,0,3,1,3);
    add(1,0,1,  0,0,2,1,3);
    add(1,0,2,  0,0,3,2,3);
    add(1,0,3,  0,1,5,3,3);
    add(1,1,0,  0,0,0,0,0);
`else
    // Clean stream, gap, mismatch in lock, reseed and relock
    add(1,0,1,  0,0,0,0,0);
    add(1,0,1,  0,0,2,0,0);
    add(0,0,0,  0,0,2,0,0);
    add(1,0,2,  0,0,3,1,0);
    add(1,0,3,  0,1,5,2,0);
    add(1,0,5,  0,1,8,3,0);
    add(1,0,8,  0,1,13,4,0);
    add(1,0,13, 0,1,21,5,0);
    add(1,0,20, 1,0,21,5,1);
    add(0,0,0,  0,0,21,5,1);
    add(1,0,30, 0,0,50,5,1);
    add(1,0,50, 0,0,80,6,1);
    add(1,0,80, 0,1,130,7,1);
    add(1,1,130,0,0,0,0,0);
    // Wrap-around past 233
    add(1,0,89, 0,0,0,0,0);
    add(1,0,144,0,0,233,0,0);
    add(1,0,233,0,0,121,1,0);
    add(1,0,121,0,1,98,2,0);
    add(1,0,98, 0,1,219,3,0);
    add(1,1,5,  0,0,0,0,0);
    // 1,1,2,4,6,10,16
    add(1,0,1,  0,0,0,0,0);
    add(1,0,1,  0,0,2,0,0);
    add(1,0,2,  0,0,3,1,0);
    add(1,0,4,  1,0,3,1,1);
    add(1,0,6,  0,0,10,1,1);
    add(1,0,10, 0,0,16,2,1);
    add(1,0,16, 0,1,26,3,1);
    add(1,1,0,  0,0,0,0,0);
`endif

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].c, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].e_err, tbl[i].e_lk,
                int'(tbl[i].e_exp), int'(tbl[i].e_tc), int'(tbl[i].e_ec));
    end

    // Gaps between samples hold state; clear coincident with valid discards the sample
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 8'(gap_d[i]));
      check_all($sformatf("gap_s%0d", i), 1'b0, 1'b0, gap_exp[i], gap_tc[i], 0);
      for (int g = 0; g < 5; g++) begin
        apply(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        check_all($sformatf("gap_h%0d_%0d", i, g), 1'b0, 1'b0, gap_exp[i], gap_tc[i], 0);
      end
    end
    apply(1'b1, 1'b1, 8'd3);
    check_all("clr_valid", 1'b0, 1'b0, 0, 0, 0);
    apply(1'b1, 1'b0, 8'd1);
    check_all("reseed_a", 1'b0, 1'b0, 0, 0, 0);
    apply(1'b1, 1'b0, 8'd1);
    check_all("reseed_b", 1'b0, 1'b0, 2, 0, 0);

    // Saturation of err_count, then asynchronous reset mid-stream
    apply(1'b0, 1'b1, 8'd0);
    repeat (600) apply(1'b1, 1'b0, 8'd200);
    chk("sat.err_count", 32'(err_count), 32'd255);
    chk("sat.term_count", 32'(term_count), 32'd0);
    repeat (3) apply(1'b1, 1'b0, 8'd200);
    chk("sat.hold", 32'(err_count), 32'd255);
    fib_valid = 1'b1;
    fib_in    = 8'd200;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 0, 0, 0);
    fib_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all("rst_held", 1'b0, 1'b0, 0, 0, 0);

    // Randomized stream against the model
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (hist.size() >= 2 && $urandom_range(0, 7) != 0)
        d = 8'((hist[hist.size()-1] + hist[hist.size()-2]) % 256);
`ifdef FIB_CHK_STRICT_SEED_EN
      else if (hist.size() < 2 && $urandom_range(0, 3) != 0)
        d = 8'd1;
`endif
      else
        d = 8'($urandom_range(0, 255));
      model_step(v, c, int'(d));
      apply(v, c, d);
      check_all($sformatf("rnd%0d", n), m_err, m_lk, m_exp, m_tc, m_ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
